full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- 1-bit full adder with a purely combinational sum/carry path.
- A clocked side-band wraps the core: output register stage, bit-serial accumulation channel, and saturating activity counters.
- Serves as the leaf adder cell for ripple/serial arithmetic.
- The combinational outputs must stay usable with clk idle and rst_n undriven.

Parameters:
- CNT_W, 16, width of op_cnt and carry_cnt (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock for all registered logic
- rst_n  input  1  asynchronous active-low reset
- a  input  1  addend bit
- b  input  1  addend bit
- c_in  input  1  carry in; also the serial-channel seed carry
- sum  output  1  combinational a^b^c_in
- c_out  output  1  combinational majority(a,b,c_in)
- en  input  1  capture strobe for the register stage and counters
- sum_q  output  1  registered sum
- c_out_q  output  1  registered c_out
- valid_q  output  1  high one cycle after an en cycle
- ser_en  input  1  advance the bit-serial channel one bit
- ser_start  input  1  first (LSB) bit of a serial operand pair
- ser_a  input  1  serial operand A bit, LSB first
- ser_b  input  1  serial operand B bit, LSB first
- ser_sum_q  output  1  registered serial sum bit
- ser_carry_q  output  1  serial carry state
- op_cnt  output  CNT_W  count of en cycles, saturating
- carry_cnt  output  CNT_W  count of en cycles with c_out=1, saturating

Behaviour:
- Combinational core:
  - sum = a XOR b XOR c_in; c_out = (a&b)|(a&c_in)|(b&c_in).
  - {c_out,sum} equals the 2-bit arithmetic value a+b+c_in for all 8 input combinations.
  - Zero latency; independent of clk, rst_n, en and all serial inputs.
- Reset (rst_n=0, asynchronous, no clock required):
  - sum_q, c_out_q, valid_q, ser_sum_q, ser_carry_q = 0; op_cnt, carry_cnt = 0.
  - Held while rst_n=0. Deasserting mid-operation discards all prior state; the first rising edge after release behaves as a fresh start.
- Register stage, each rising clk edge:
  - en=1: sum_q<=sum, c_out_q<=c_out, valid_q<=1.
  - en=0: valid_q<=0; sum_q and c_out_q hold.
  - Latency from en cycle to outputs: 1 clock.
- Counters, each rising edge with en=1:
  - op_cnt<=op_cnt+1 unless all-ones (saturates, never wraps).
  - If c_out=1: carry_cnt<=carry_cnt+1, same saturation rule.
  - Both counters are updated in the same edge; carry_cnt <= op_cnt always holds.
- Serial channel, each rising edge with ser_en=1:
  - cin_s = ser_start ? c_in : ser_carry_q.
  - ser_sum_q <= ser_a^ser_b^cin_s; ser_carry_q <= majority(ser_a,ser_b,cin_s).
  - ser_en=0: ser_sum_q and ser_carry_q hold. ser_start is ignored when ser_en=0.
  - An N-bit add takes N ser_en cycles; sum bit k appears one cycle after its inputs. The final carry is ser_carry_q after the last bit.
  - ser_start mid-stream aborts the previous operation; the old carry is dropped.
- en and ser_en are independent; simultaneous assertion is legal and neither affects the other.
- No X propagation from unused inputs into sum/c_out.

Test Plan:
- Exhaustive combinational check, clk idle: {c_in,a,b}=0..7 -> {c_out,sum} = 00,01,01,10,01,10,10,11 respectively, checked 10 ns after each change.
- Reset then registered capture: rst_n=0 -> all registered outputs 0. Release, drive a=1,b=1,c_in=0, en=1 one cycle -> next cycle sum_q=0, c_out_q=1, valid_q=1. Following cycle with en=0 -> valid_q=0, sum_q/c_out_q hold.
- Counter saturation with CNT_W=2: 5 en cycles with a=b=c_in=1 -> op_cnt=3, carry_cnt=3, no wrap. Then one en cycle with a=b=c_in=0 -> both counters stay 3.
- Serial 4-bit add 0xB+0x6, c_in=0:
  - ser_start on bit0, ser_en 4 cycles, LSB first.
  - ser_sum_q sequence 1,0,0,0; final ser_carry_q=1 (result 0x11).
- Serial seed carry and abort:
  - c_in=1 with ser_start, 2-bit add 01+01 -> ser_sum_q 1,1; carry 0 (result 3).
  - Reasserting ser_start mid-stream restarts using c_in, not ser_carry_q.
- Asynchronous reset mid-serial-operation: rst_n pulsed low between clock edges -> ser_carry_q, ser_sum_q, counters immediately 0. Combinational sum/c_out keep tracking a,b,c_in throughout.

Source files
------------

// File: rtl/full_adder.sv
// 1-bit full adder leaf cell with a clocked side-band: output register stage,
// bit-serial add channel and saturating activity counters.
module full_adder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c_in,
  output logic             sum,
  output logic             c_out,
  input  logic             en,
  output logic             sum_q,
  output logic             c_out_q,
  output logic             valid_q,
  input  logic             ser_en,
  input  logic             ser_start,
  input  logic             ser_a,
  input  logic             ser_b,
  output logic             ser_sum_q,
  output logic             ser_carry_q,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] carry_cnt
);

  logic             sum_d, c_out_d, valid_d;
  logic             ser_sum_d, ser_carry_d, ser_cin;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;

  // Core path depends only on a/b/c_in so it works with clk idle and rst_n floating.
  always_comb begin
    sum   = a ^ b ^ c_in;
    c_out = (a & b) | (a & c_in) | (b & c_in);
  end

  always_comb begin
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    valid_d     = 1'b0;
    op_cnt_d    = op_cnt_q;
    carry_cnt_d = carry_cnt_q;
    if (en) begin
      sum_d   = sum;
      c_out_d = c_out;
      valid_d = 1'b1;
      if (op_cnt_q != '1) begin
        op_cnt_d = op_cnt_q + CNT_W'(1);
      end
      if (c_out && (carry_cnt_q != '1)) begin
        carry_cnt_d = carry_cnt_q + CNT_W'(1);
      end
    end
  end

  // ser_start reseeds from c_in, dropping any carry left by an aborted operation.
  always_comb begin
    ser_cin     = ser_start ? c_in : ser_carry_q;
    ser_sum_d   = ser_sum_q;
    ser_carry_d = ser_carry_q;
    if (ser_en) begin
      ser_sum_d   = ser_a ^ ser_b ^ ser_cin;
      ser_carry_d = (ser_a & ser_b) | (ser_a & ser_cin) | (ser_b & ser_cin);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= 1'b0;
      c_out_q     <= 1'b0;
      valid_q     <= 1'b0;
      ser_sum_q   <= 1'b0;
      ser_carry_q <= 1'b0;
      op_cnt_q    <= '0;
      carry_cnt_q <= '0;
    end else begin
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      valid_q     <= valid_d;
      ser_sum_q   <= ser_sum_d;
      ser_carry_q <= ser_carry_d;
      op_cnt_q    <= op_cnt_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign op_cnt    = op_cnt_q;
  assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: arithmetic reference model, directed
// literal checks and a randomized phase, on a 4-bit and a 2-bit counter instance.
module tb_full_adder;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n;
  logic a, b, c_in, en, ser_en, ser_start, ser_a, ser_b;

  logic       sum, c_out, sum_q, c_out_q, valid_q, ser_sum_q, ser_carry_q;
  logic [3:0] op_cnt, carry_cnt;
  logic       s_sum, s_c_out, s_sum_q, s_c_out_q, s_valid_q, s_ser_sum_q, s_ser_carry_q;
  logic [1:0] s_op_cnt, s_carry_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  full_adder #(.CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in), .sum(sum), .c_out(c_out),
    .en(en), .sum_q(sum_q), .c_out_q(c_out_q), .valid_q(valid_q),
    .ser_en(ser_en), .ser_start(ser_start), .ser_a(ser_a), .ser_b(ser_b),
    .ser_sum_q(ser_sum_q), .ser_carry_q(ser_carry_q), .op_cnt(op_cnt), .carry_cnt(carry_cnt)
  );

  full_adder #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in), .sum(s_sum), .c_out(s_c_out),
    .en(en), .sum_q(s_sum_q), .c_out_q(s_c_out_q), .valid_q(s_valid_q),
    .ser_en(ser_en), .ser_start(ser_start), .ser_a(ser_a), .ser_b(ser_b),
    .ser_sum_q(s_ser_sum_q), .ser_carry_q(s_ser_carry_q), .op_cnt(s_op_cnt), .carry_cnt(s_carry_cnt)
  );

  always #5 if (clk_run) clk = ~clk;

  // Reference model: plain integer arithmetic on the adder rules.
  int m_sum, m_cout, m_valid, m_ssum, m_scarry, m_op4, m_cc4, m_op2, m_cc2;

  function automatic int tot3(logic x, logic y, logic z);
    return int'(x) + int'(y) + int'(z);
  endfunction

  function automatic int sat_inc(int v, int maxv);
    return (v < maxv) ? v + 1 : maxv;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum <= 0; m_cout <= 0; m_valid <= 0; m_ssum <= 0; m_scarry <= 0;
      m_op4 <= 0; m_cc4 <= 0; m_op2 <= 0; m_cc2 <= 0;
    end else begin
      m_valid <= en ? 1 : 0;
      if (en) begin
        m_sum  <= tot3(a, b, c_in) % 2;
        m_cout <= tot3(a, b, c_in) / 2;
        m_op4  <= sat_inc(m_op4, 15);
        m_op2  <= sat_inc(m_op2, 3);
        if (tot3(a, b, c_in) >= 2) begin
          m_cc4 <= sat_inc(m_cc4, 15);
          m_cc2 <= sat_inc(m_cc2, 3);
        end
      end
      if (ser_en) begin
        m_ssum   <= tot3(ser_a, ser_b, ser_start ? c_in : m_scarry[0]) % 2;
        m_scarry <= tot3(ser_a, ser_b, ser_start ? c_in : m_scarry[0]) / 2;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("cmp_comb",      int'({c_out, sum}),     tot3(a, b, c_in));
      check("cmp_comb_sat",  int'({s_c_out, s_sum}), tot3(a, b, c_in));
      check("cmp_sum_q",     int'(sum_q),       m_sum);
      check("cmp_c_out_q",   int'(c_out_q),     m_cout);
      check("cmp_valid_q",   int'(valid_q),     m_valid);
      check("cmp_ser_sum",   int'(ser_sum_q),   m_ssum);
      check("cmp_ser_carry", int'(ser_carry_q), m_scarry);
      check("cmp_op4",       int'(op_cnt),      m_op4);
      check("cmp_cc4",       int'(carry_cnt),   m_cc4);
      check("cmp_op2",       int'(s_op_cnt),    m_op2);
      check("cmp_cc2",       int'(s_carry_cnt), m_cc2);
      check("cmp_sat_regs",  int'({s_sum_q, s_c_out_q, s_valid_q, s_ser_sum_q, s_ser_carry_q}),
            int'({sum_q, c_out_q, valid_q, ser_sum_q, ser_carry_q}) ^ 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sbit(input logic st, input logic sa, input logic sb);
    ser_en = 1'b1; ser_start = st; ser_a = sa; ser_b = sb;
    tick();
    ser_en = 1'b0; ser_start = 1'b0;
  endtask

  initial begin
    int exp_tab [8];
    logic [2:0] v;
    exp_tab = '{0, 1, 1, 2, 1, 2, 2, 3};

    // Clock idle, rst_n and side inputs undriven.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {c_in, a, b} = v;
      #10;
      check("exhaustive", int'({c_out, sum}), exp_tab[i]);
    end

    en = 1'b0; ser_en = 1'b0; ser_start = 1'b0; ser_a = 1'b0; ser_b = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_regs",  int'({sum_q, c_out_q, valid_q, ser_sum_q, ser_carry_q}), 0);
    check("rst_cnts",  int'({op_cnt, carry_cnt}), 0);
    check("rst_sat",   int'({s_op_cnt, s_carry_cnt}), 0);

    clk_run = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;

    // Registered capture.
    tick();
    a = 1'b1; b = 1'b1; c_in = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    check("cap_sum_q",   int'(sum_q),   0);
    check("cap_c_out_q", int'(c_out_q), 1);
    check("cap_valid_q", int'(valid_q), 1);
    tick();
    check("hold_valid_q", int'(valid_q), 0);
    check("hold_regs",    int'({sum_q, c_out_q}), 1);

    // Counter saturation.
    rst_n = 1'b0; #1 rst_n = 1'b1;
    a = 1'b1; b = 1'b1; c_in = 1'b1; en = 1'b1;
    repeat (5) tick();
    check("sat_op2", int'(s_op_cnt),    3);
    check("sat_cc2", int'(s_carry_cnt), 3);
    check("sat_op4", int'(op_cnt),      5);
    a = 1'b0; b = 1'b0; c_in = 1'b0;
    tick();
    en = 1'b0;
    check("sat_op2_hold", int'(s_op_cnt),    3);
    check("sat_cc2_hold", int'(s_carry_cnt), 3);
    check("op4_six",      int'(op_cnt),      6);
    check("cc4_five",     int'(carry_cnt),   5);

    // Serial 0xB + 0x6, LSB first.
    c_in = 1'b0;
    sbit(1'b1, 1'b1, 1'b0); check("ser_b0", int'(ser_sum_q), 1);
    sbit(1'b0, 1'b1, 1'b1); check("ser_b1", int'(ser_sum_q), 0);
    sbit(1'b0, 1'b0, 1'b1); check("ser_b2", int'(ser_sum_q), 0);
    sbit(1'b0, 1'b1, 1'b0); check("ser_b3", int'(ser_sum_q), 0);
    check("ser_final_carry", int'(ser_carry_q), 1);

    // Seeded 01 + 01 with c_in=1.
    c_in = 1'b1;
    sbit(1'b1, 1'b1, 1'b1); check("seed_b0", int'(ser_sum_q), 1);
    c_in = 1'b0;
    sbit(1'b0, 1'b0, 1'b0); check("seed_b1", int'(ser_sum_q), 1);
    check("seed_carry", int'(ser_carry_q), 0);

    // ser_start ignored while ser_en=0, then abort restarts from c_in.
    sbit(1'b1, 1'b1, 1'b1);
    check("abort_pre_carry", int'(ser_carry_q), 1);
    ser_start = 1'b1;
    tick();
    ser_start = 1'b0;
    check("start_ignored", int'(ser_carry_q), 1);
    sbit(1'b1, 1'b0, 1'b0);
    check("abort_sum",   int'(ser_sum_q),   0);
    check("abort_carry", int'(ser_carry_q), 0);

    // Async reset between edges mid-operation.
    c_in = 1'b1; en = 1'b1;
    sbit(1'b1, 1'b1, 1'b0);
    en = 1'b0;
    check("pre_rst_carry", int'(ser_carry_q), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ser",  int'({ser_sum_q, ser_carry_q}), 0);
    check("arst_cnts", int'({op_cnt, carry_cnt, s_op_cnt, s_carry_cnt}), 0);
    a = 1'b1; b = 1'b0; c_in = 1'b1;
    #1;
    check("arst_comb", int'({c_out, sum}), 2);
    rst_n = 1'b1;

    // Randomized phase with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      tick();
      a = 1'($urandom); b = 1'($urandom); c_in = 1'($urandom);
      en = 1'($urandom); ser_en = 1'($urandom);
      ser_start = ($urandom_range(0, 5) == 0);
      ser_a = 1'($urandom); ser_b = 1'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    tick();
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
